glb_port_arbiter: RTL

Round-robin arbiter sharing the single GLB SRAM port (SRAM_64KB) between up to four requesters: the token_engine weight, ifmap, ipsum/bias and opsum-writeback channels. It grants one access per cycle and routes the 1-cycle-latency read data back to the requester that issued the read. It supports locked bursts so that a loader can stream consecutive words without interleaving.

---
 rtl/glb_pkg.sv | 21 ++
 rtl/glb_port_arbiter_rr_pick.sv | 32 +++
 rtl/glb_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/glb_pkg.sv
// Shared constants and types for the GLB SRAM port arbiter.
package glb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned GLB_ADDR_W  = 32;
  localparam int unsigned GLB_DATA_W  = 32;
  localparam int unsigned GLB_BYTES   = GLB_DATA_W / 8;

  localparam int unsigned REQ_WEIGHT = 0;
  localparam int unsigned REQ_IFMAP  = 1;
  localparam int unsigned REQ_IPSUM  = 2;
  localparam int unsigned REQ_OPSUM  = 3;

  localparam logic [GLB_BYTES-1:0] WEB_READ = '1;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/glb_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above ptr_i, with wrap.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int unsigned IW = $clog2(N);

  always_comb begin
    int unsigned k;
    logic        found;
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    k        = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr_i) + i) % N;
      if (!found && req_i[IW'(k)]) begin
        found             = 1'b1;
        idx_o             = IW'(k);
        onehot_o[IW'(k)]  = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/glb_port_arbiter.sv
// Round-robin arbiter for the single GLB SRAM port with locked bursts and
// 1-cycle read-data return to the issuing requester.
module glb_port_arbiter
  import glb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ADDR_W  = GLB_ADDR_W,
  parameter int unsigned DATA_W  = GLB_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              lock_i,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]   web_i,
  input  logic [NUM_REQ*ADDR_W-1:0]       addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]       wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_W-1:0]               rdata_o,
  output logic [$clog2(NUM_REQ)-1:0]      owner_o,
  output logic                            locked_o,
  output logic [DATA_W/8-1:0]             glb_web_o,
  output logic [ADDR_W-1:0]               glb_addr_o,
  output logic [DATA_W-1:0]               glb_write_data_o,
  input  logic [DATA_W-1:0]               glb_read_data_i
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned NB = DATA_W / 8;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          rd_valid_q, rd_valid_d;
  logic [IW-1:0] rd_id_q, rd_id_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic [IW-1:0] next_ptr;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Grant decision and next-state; reset also silences the port combinationally.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    gnt_o    = '0;
    gnt_idx  = owner_q;
    gnt_any  = 1'b0;
    next_ptr = '0;
    if (!rst) begin
      unique case (state_q)
        ARB: begin
          if (pick_any) begin
            gnt_o    = pick_onehot;
            gnt_idx  = pick_idx;
            gnt_any  = 1'b1;
            owner_d  = pick_idx;
            next_ptr = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
            if (lock_i[pick_idx]) state_d  = LOCKED;
            else                  rr_ptr_d = next_ptr;
          end
        end
        LOCKED: begin
          next_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
          if (req_i[owner_q]) begin
            gnt_o[owner_q] = 1'b1;
            gnt_any        = 1'b1;
            if (!lock_i[owner_q]) begin
              state_d  = ARB;
              rr_ptr_d = next_ptr;
            end
          end else begin
            state_d  = ARB;
            rr_ptr_d = next_ptr;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // SRAM port mux; idle port reads nothing and drives zeros.
  always_comb begin
    glb_web_o        = '1;
    glb_addr_o       = '0;
    glb_write_data_o = '0;
    if (gnt_any) begin
      glb_web_o        = web_i[32'(gnt_idx) * NB +: NB];
      glb_addr_o       = addr_i[32'(gnt_idx) * ADDR_W +: ADDR_W];
      glb_write_data_o = wdata_i[32'(gnt_idx) * DATA_W +: DATA_W];
    end
    rd_valid_d = gnt_any && (&glb_web_o);
    rd_id_d    = gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
    end
  end

  assign rvalid_o = rd_valid_q ? (NUM_REQ'(1) << rd_id_q) : '0;
  assign rdata_o  = glb_read_data_i;
  assign owner_o  = owner_q;
  assign locked_o = (state_q == LOCKED);

endmodule
